// File: rtl/vldrdy_merger.sv
// -----------------------------------------------------------------------------
// vldrdy_merger
//
// Purpose:
//   Recombines the two valid/ready channels coming out of the distributor
//   stage into a single stream. The two inputs are arbitrated round-robin.
//   Accepted beats go into a 2-entry output FIFO whose head register drives
//   dn_* directly. Because of this, dn_ready never reaches up*_ready
//   combinationally. Every output beat carries the index of its source
//   channel. Each input also has a saturating transfer counter for debug.
//
// Parameters:
//   DATA_W : payload width of each input and of the output
//   CNT_W  : width of the per-input accepted-transfer counters
//
// Ports:
//   clock      in   single clock, all state updates on posedge
//   reset      in   asynchronous, active-high reset
//   up1_valid  in   channel 1 valid
//   up1_ready  out  channel 1 ready
//   up1_data   in   channel 1 payload
//   up2_valid  in   channel 2 valid
//   up2_ready  out  channel 2 ready
//   up2_data   in   channel 2 payload
//   dn_valid   out  merged output valid (registered)
//   dn_ready   in   merged output ready
//   dn_data    out  merged output payload (registered)
//   dn_src     out  source of current dn beat: 0 = up1, 1 = up2
//   cnt1       out  accepted up1 transfers, saturating
//   cnt2       out  accepted up2 transfers, saturating
// -----------------------------------------------------------------------------
module vldrdy_merger #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              up1_valid,
   output logic              up1_ready,
   input  logic [DATA_W-1:0] up1_data,
   input  logic              up2_valid,
   output logic              up2_ready,
   input  logic [DATA_W-1:0] up2_data,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [DATA_W-1:0] dn_data,
   output logic              dn_src,
   output logic [CNT_W-1:0]  cnt1,
   output logic [CNT_W-1:0]  cnt2
);

   // One buffered beat: source tag plus payload.
   typedef struct packed {
      logic              src;
      logic [DATA_W-1:0] data;
   } beat_t;

   // Entry 0 is always the FIFO head and feeds dn_* directly.
   beat_t             ent0_q, ent0_d;
   beat_t             ent1_q, ent1_d;
   logic [1:0]        occ_q, occ_d;
   logic              dn_valid_q, dn_valid_d;
   // Priority pointer: 0 = up1 wins a tie, 1 = up2 wins a tie.
   logic              ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt1_q, cnt1_d;
   logic [CNT_W-1:0]  cnt2_q, cnt2_d;

   logic              any_valid;
   logic              grant_sel;   // 0 = up1, 1 = up2; meaningful only with any_valid
   logic              accept;
   logic              push;
   logic              pop;
   beat_t             in_beat;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + 1'b1;
   endfunction

   // ---------------------------------------------------------------------
   // Arbitration and handshake
   // ---------------------------------------------------------------------
   // accept depends only on occupancy, never on dn_ready. A full buffer
   // therefore refuses a push even in a cycle where it is popped.
   always_comb begin
      any_valid = up1_valid | up2_valid;
      if (up1_valid && up2_valid) begin
         grant_sel = ptr_q;
      end else begin
         grant_sel = up2_valid;
      end
      accept    = (occ_q != 2'd2);
      up1_ready = accept & any_valid & ~grant_sel;
      up2_ready = accept & any_valid &  grant_sel;
      push      = accept & any_valid;
      pop       = dn_valid_q & dn_ready;
      in_beat.src  = grant_sel;
      in_beat.data = grant_sel ? up2_data : up1_data;
   end

   // ---------------------------------------------------------------------
   // Next-state: FIFO, pointer, counters
   // ---------------------------------------------------------------------
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      ptr_d  = ptr_q;
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;

      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               ent0_d = in_beat;
            end else begin
               ent1_d = in_beat;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
         end
         // Push and pop together can only happen with exactly one entry.
         // The new beat replaces the departing head, and occupancy holds.
         2'b11: begin
            ent0_d = in_beat;
         end
         default: begin
         end
      endcase

      if (push) begin
         ptr_d = ~grant_sel;
         if (grant_sel) begin
            cnt2_d = sat_inc(cnt2_q);
         end else begin
            cnt1_d = sat_inc(cnt1_q);
         end
      end

      dn_valid_d = (occ_d != 2'd0);
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ent0_q     <= '0;
         ent1_q     <= '0;
         occ_q      <= 2'd0;
         dn_valid_q <= 1'b0;
         ptr_q      <= 1'b0;
         cnt1_q     <= '0;
         cnt2_q     <= '0;
      end else begin
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
         occ_q      <= occ_d;
         dn_valid_q <= dn_valid_d;
         ptr_q      <= ptr_d;
         cnt1_q     <= cnt1_d;
         cnt2_q     <= cnt2_d;
      end
   end

   assign dn_valid = dn_valid_q;
   assign dn_data  = ent0_q.data;
   assign dn_src   = ent0_q.src;
   assign cnt1     = cnt1_q;
   assign cnt2     = cnt2_q;

endmodule

// File: tb/tb_vldrdy_merger.sv
// -----------------------------------------------------------------------------
// tb_vldrdy_merger
//
// Purpose: self-checking bench for vldrdy_merger. Table-driven cycle vectors
// cover single-channel streaming, fair interleave and backpressure.
// Hand-written sequences cover counter saturation, reset in the middle of a
// transfer, and a randomized soak with a scoreboard. The counter width is 4 so
// that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_vldrdy_merger;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          up1_valid = 1'b0;
   logic          up1_ready;
   logic [DW-1:0] up1_data = '0;
   logic          up2_valid = 1'b0;
   logic          up2_ready;
   logic [DW-1:0] up2_data = '0;
   logic          dn_valid;
   logic          dn_ready = 1'b0;
   logic [DW-1:0] dn_data;
   logic          dn_src;
   logic [CW-1:0] cnt1;
   logic [CW-1:0] cnt2;

   int total = 0;
   int bad   = 0;

   vldrdy_merger #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clock     (clock),
      .reset     (reset),
      .up1_valid (up1_valid),
      .up1_ready (up1_ready),
      .up1_data  (up1_data),
      .up2_valid (up2_valid),
      .up2_ready (up2_ready),
      .up2_data  (up2_data),
      .dn_valid  (dn_valid),
      .dn_ready  (dn_ready),
      .dn_data   (dn_data),
      .dn_src    (dn_src),
      .cnt1      (cnt1),
      .cnt2      (cnt2)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One vector = one clock cycle. Inputs are driven after a negedge.
   // Expected values are the outputs seen before the following posedge.
   typedef struct {
      logic          rst_before;
      logic          v1;
      logic [DW-1:0] d1;
      logic          v2;
      logic [DW-1:0] d2;
      logic          dr;
      logic          r1;
      logic          r2;
      logic          dv;
      logic [DW-1:0] dd;
      logic          src;
      int            c1;
      int            c2;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic rb, input logic v1, input logic [DW-1:0] d1,
                               input logic v2, input logic [DW-1:0] d2, input logic dr,
                               input logic r1, input logic r2, input logic dv,
                               input logic [DW-1:0] dd, input logic src,
                               input int c1, input int c2);
      vec_t t;
      t.rst_before = rb; t.v1 = v1; t.d1 = d1; t.v2 = v2; t.d2 = d2; t.dr = dr;
      t.r1 = r1; t.r2 = r2; t.dv = dv; t.dd = dd; t.src = src; t.c1 = c1; t.c2 = c2;
      tbl.push_back(t);
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      up1_valid = 1'b0;
      up2_valid = 1'b0;
      dn_ready  = 1'b0;
      @(negedge clock);
      #1;
      check("rst_dn_valid", dn_valid, 0);
      check("rst_dn_data", dn_data, 0);
      check("rst_dn_src", dn_src, 0);
      check("rst_cnt1", cnt1, 0);
      check("rst_cnt2", cnt2, 0);
      reset = 1'b0;
   endtask

   // Invariant monitor: samples 1 time unit after each posedge. Inputs only
   // change at negedges, so dn_ready here is the value used at the edge.
   logic          prev_dv = 1'b0;
   logic [DW-1:0] prev_dd = '0;
   logic          prev_src = 1'b0;
   always begin
      @(posedge clock);
      #1;
      if (reset) begin
         prev_dv = 1'b0;
      end else begin
         if (up1_ready && up2_ready) begin
            check("mon_ready_exclusive", 1, 0);
         end
         if (prev_dv && !dn_ready) begin
            check("mon_dv_hold", dn_valid, 1);
            check("mon_dd_stable", {dn_src, dn_data}, {prev_src, prev_dd});
         end
         prev_dv  = dn_valid;
         prev_dd  = dn_data;
         prev_src = dn_src;
      end
   end

   logic [8:0] exp_q[$];
   int sent1, sent2, recv;
   logic [8:0] exp_beat;

   initial begin
      // ---- Test 1: up1 only, streaming 0x10..0x13
      //   rb v1 d1     v2 d2     dr  r1 r2 dv dd     src c1 c2
      add(1, 1, 8'h10, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0,  0, 0);
      add(0, 1, 8'h11, 0, 8'h00, 1,  1, 0, 1, 8'h10, 0,  1, 0);
      add(0, 1, 8'h12, 0, 8'h00, 1,  1, 0, 1, 8'h11, 0,  2, 0);
      add(0, 1, 8'h13, 0, 8'h00, 1,  1, 0, 1, 8'h12, 0,  3, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h13, 0,  4, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0,  4, 0);
      // ---- Test 2: fair interleave A0,B0,A1,B1
      add(1, 1, 8'hA0, 1, 8'hB0, 1,  1, 0, 0, 8'h00, 0,  0, 0);
      add(0, 1, 8'hA1, 1, 8'hB0, 1,  0, 1, 1, 8'hA0, 0,  1, 0);
      add(0, 1, 8'hA1, 1, 8'hB1, 1,  1, 0, 1, 8'hB0, 1,  1, 1);
      add(0, 0, 8'h00, 1, 8'hB1, 1,  0, 1, 1, 8'hA1, 0,  2, 1);
      add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'hB1, 1,  2, 2);
      add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0,  2, 2);
      // ---- Test 3: backpressure, fill to 2 then drain
      add(0, 1, 8'hC0, 1, 8'hD0, 0,  1, 0, 0, 8'h00, 0,  2, 2);
      add(0, 1, 8'hC1, 1, 8'hD0, 0,  0, 1, 1, 8'hC0, 0,  3, 2);
      add(0, 1, 8'hC1, 1, 8'hD1, 0,  0, 0, 1, 8'hC0, 0,  3, 3);
      add(0, 1, 8'hC1, 1, 8'hD1, 0,  0, 0, 1, 8'hC0, 0,  3, 3);
      add(0, 1, 8'hC1, 1, 8'hD1, 1,  0, 0, 1, 8'hC0, 0,  3, 3);
      add(0, 1, 8'hC1, 1, 8'hD1, 1,  1, 0, 1, 8'hD0, 1,  3, 3);
      add(0, 1, 8'hC2, 1, 8'hD1, 1,  0, 1, 1, 8'hC1, 0,  4, 3);
      add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'hD1, 1,  4, 4);
      add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0,  4, 4);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst_before) begin
            do_reset();
         end
         @(negedge clock);
         up1_valid = tbl[i].v1;
         up1_data  = tbl[i].d1;
         up2_valid = tbl[i].v2;
         up2_data  = tbl[i].d2;
         dn_ready  = tbl[i].dr;
         #1;
         check($sformatf("vec%0d_up1_ready", i), up1_ready, tbl[i].r1);
         check($sformatf("vec%0d_up2_ready", i), up2_ready, tbl[i].r2);
         check($sformatf("vec%0d_dn_valid", i), dn_valid, tbl[i].dv);
         if (tbl[i].dv) begin
            check($sformatf("vec%0d_dn_data", i), dn_data, tbl[i].dd);
            check($sformatf("vec%0d_dn_src", i), dn_src, tbl[i].src);
         end
         check($sformatf("vec%0d_cnt1", i), cnt1, tbl[i].c1);
         check($sformatf("vec%0d_cnt2", i), cnt2, tbl[i].c2);
      end

      // ---- Test 4: saturation, 20 beats on up2 with CNT_W = 4
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         up1_valid = 1'b0;
         up2_valid = 1'b1;
         up2_data  = 8'(i);
         dn_ready  = 1'b1;
         #1;
         check("sat_up2_ready", up2_ready, 1);
         check("sat_cnt2", cnt2, (i > 15) ? 15 : i);
         if (i > 0) begin
            check("sat_dn_beat", {dn_valid, dn_src, dn_data}, {2'b11, 8'(i - 1)});
         end
      end
      @(negedge clock);
      up2_valid = 1'b0;
      #1;
      check("sat_cnt2_final", cnt2, 15);
      check("sat_cnt1_final", cnt1, 0);

      // ---- Test 5: asynchronous reset with 2 beats buffered, pointer at up2
      do_reset();
      @(negedge clock);
      up1_valid = 1'b1; up1_data = 8'h55; up2_valid = 1'b0; dn_ready = 1'b0;
      #1;
      check("mid_fill1_ready", up1_ready, 1);
      @(negedge clock);
      up1_data = 8'h56;
      #1;
      check("mid_fill2_ready", up1_ready, 1);
      @(negedge clock);
      up2_valid = 1'b1; up2_data = 8'h66;
      #1;
      check("mid_full_readys", {up1_ready, up2_ready}, 2'b00);
      check("mid_full_head", {dn_valid, dn_src, dn_data}, {2'b10, 8'h55});
      check("mid_full_cnt1", cnt1, 2);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_dn_valid", dn_valid, 0);
      check("mid_rst_cnt1", cnt1, 0);
      check("mid_rst_cnt2", cnt2, 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("mid_post_grant", {up1_ready, up2_ready}, 2'b10);
      @(negedge clock);
      up1_valid = 1'b0; up2_valid = 1'b0;
      #1;
      check("mid_post_beat", {dn_valid, dn_src, dn_data}, {2'b10, 8'h56});
      dn_ready = 1'b1;

      // ---- Test 6: random soak with scoreboard
      do_reset();
      sent1 = 0; sent2 = 0; recv = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 3000 && recv < 64; cyc++) begin
         @(negedge clock);
         up1_valid = (sent1 < 32) && ($urandom_range(0, 3) != 0);
         up1_data  = 8'(sent1);
         up2_valid = (sent2 < 32) && ($urandom_range(0, 3) != 0);
         up2_data  = 8'h80 | 8'(sent2);
         dn_ready  = ($urandom_range(0, 3) != 0);
         #1;
         if (dn_valid && dn_ready) begin
            if (exp_q.size() == 0) begin
               check("soak_unexpected_beat", {dn_src, dn_data}, 9'h1ff);
            end else begin
               exp_beat = exp_q.pop_front();
               check("soak_order", {dn_src, dn_data}, exp_beat);
            end
            recv++;
         end
         if (up1_valid && up1_ready) begin
            exp_q.push_back({1'b0, up1_data});
            sent1++;
         end
         if (up2_valid && up2_ready) begin
            exp_q.push_back({1'b1, up2_data});
            sent2++;
         end
      end
      check("soak_recv", recv, 64);
      check("soak_sent1", sent1, 32);
      check("soak_sent2", sent2, 32);
      check("soak_cnt1_sat", cnt1, 15);
      check("soak_cnt2_sat", cnt2, 15);

      @(negedge clock);
      up1_valid = 1'b0;
      up2_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
